// File: rtl/eaglesong_absorb.sv
// eaglesong_absorb: absorbing-phase front end for the Eaglesong sponge.
// Packs a byte stream into 32-bit words, appends the delimiter, XORs each
// 256-bit rate block into the 512-bit state and runs the permutation once
// per block. Optional feature macro: EAGLESONG_ABSORB_LEN_CNT_EN adds the
// msg_len output (saturating count of accepted message bytes).
module eaglesong_absorb #(
    parameter logic [7:0] DELIMITER = 8'h06
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [15:0][31:0] perm_state,
    output logic              perm_start,
    input  logic [15:0][31:0] perm_result,
    input  logic              perm_done,
    output logic [15:0][31:0] state_out,
    output logic              state_valid,
    input  logic              state_ack
`ifdef EAGLESONG_ABSORB_LEN_CNT_EN
    ,
    output logic [31:0]       msg_len
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             cur, nxt;
    logic [15:0][31:0]  st;          // sponge state
    logic [7:0][31:0]   rbuf;        // rate block being filled
    logic [4:0]         bc;          // byte position within the block
    logic               final_blk;   // the block in flight is the last one
    logic               pad_only;    // message ended on a block boundary
    logic               accept;
    logic               done_hit;
    logic [2:0]         widx, didx;
    logic [31:0]        shifted, with_delim;

    assign state_out = st;

    // next-state decode and byte packing helpers
    always_comb begin
        nxt        = cur;
        accept     = in_valid && in_ready && (cur == S_IDLE || cur == S_FILL);
        // perm_start is high exactly during the first WAIT cycle, so it masks
        // a done level left over from the previous block
        done_hit   = (cur == S_WAIT) && perm_done && !perm_start;
        widx       = bc[4:2];
        didx       = widx + 3'd1;
        shifted    = (rbuf[widx] << 8) ^ {24'h0, in_data};
        with_delim = (shifted << 8) ^ {24'h0, DELIMITER};
        case (cur)
            S_IDLE, S_FILL: begin
                if (accept) begin
                    if (in_last || bc == 5'd31) nxt = S_LAUNCH;
                    else                        nxt = S_FILL;
                end
            end
            S_LAUNCH: nxt = S_WAIT;
            S_WAIT: begin
                if (done_hit) begin
                    if (final_blk)     nxt = S_DONE;
                    else if (pad_only) nxt = S_LAUNCH;
                    else               nxt = S_FILL;
                end
            end
            S_DONE: begin
                if (state_ack) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // state register and registered handshake/status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur         <= S_IDLE;
            in_ready    <= 1'b0;
            state_valid <= 1'b0;
            perm_start  <= 1'b0;
        end else begin
            cur         <= nxt;
            in_ready    <= (nxt == S_IDLE) || (nxt == S_FILL);
            state_valid <= (nxt == S_DONE);
            perm_start  <= (cur == S_LAUNCH);
        end
    end

    // datapath: packing, launch vector, result capture and clearing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st         <= '0;
            rbuf       <= '0;
            bc         <= '0;
            final_blk  <= 1'b0;
            pad_only   <= 1'b0;
            perm_state <= '0;
        end else begin
            case (cur)
                S_IDLE, S_FILL: begin
                    if (accept) begin
                        bc <= bc + 5'd1;
                        if (in_last && bc != 5'd31) begin
                            final_blk <= 1'b1;
                            // delimiter is the byte after the last one; it
                            // opens the next word when the current one is full
                            if (bc[1:0] == 2'd3) begin
                                rbuf[widx] <= shifted;
                                rbuf[didx] <= {24'h0, DELIMITER};
                            end else begin
                                rbuf[widx] <= with_delim;
                            end
                        end else begin
                            rbuf[widx] <= shifted;
                            if (in_last) pad_only <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    for (int i = 0; i < 8; i++) perm_state[i] <= st[i] ^ rbuf[i];
                    for (int i = 8; i < 16; i++) perm_state[i] <= st[i];
                    rbuf <= '0;
                    bc   <= '0;
                end
                S_WAIT: begin
                    if (done_hit) begin
                        st <= perm_result;
                        if (!final_blk && pad_only) begin
                            rbuf[0]   <= {24'h0, DELIMITER};
                            final_blk <= 1'b1;
                            pad_only  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (state_ack) begin
                        st        <= '0;
                        final_blk <= 1'b0;
                        pad_only  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef EAGLESONG_ABSORB_LEN_CNT_EN
    // saturating count of accepted bytes, cleared when the result is released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_len <= '0;
        end else if (cur == S_DONE && state_ack) begin
            msg_len <= '0;
        end else if (accept && msg_len != 32'hFFFF_FFFF) begin
            msg_len <= msg_len + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eaglesong_absorb.sv
// Table-driven bench for eaglesong_absorb with a stand-in permutation model
// (simple word mix with configurable latency and a level done output).
module tb_eaglesong_absorb;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [15:0][31:0] perm_state;
    logic              perm_start;
    logic [15:0][31:0] perm_result = '0;
    logic              perm_done;
    logic [15:0][31:0] state_out;
    logic              state_valid;
    logic              state_ack = 1'b0;
`ifdef EAGLESONG_ABSORB_LEN_CNT_EN
    logic [31:0]       msg_len;
`endif

    eaglesong_absorb dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .perm_state(perm_state), .perm_start(perm_start),
        .perm_result(perm_result), .perm_done(perm_done),
        .state_out(state_out), .state_valid(state_valid), .state_ack(state_ack)
`ifdef EAGLESONG_ABSORB_LEN_CNT_EN
        , .msg_len(msg_len)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // stand-in permutation: rotate-and-mix of neighbouring words
    function automatic logic [15:0][31:0] pmodel(input logic [15:0][31:0] s);
        logic [15:0][31:0] r;
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w    = s[(i + 3) % 16];
            r[i] = {w[15:0], w[31:16]} ^ (32'h9E3779B9 * 32'(i + 1)) ^ s[i];
        end
        return r;
    endfunction

    int lat_cfg = 0;
    int cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perm_done <= 1'b0;
            cnt       <= 0;
        end else if (perm_start) begin
            perm_result <= pmodel(perm_state);
            if (lat_cfg == 0) perm_done <= 1'b1;
            else begin
                perm_done <= 1'b0;
                cnt       <= lat_cfg;
            end
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) perm_done <= 1'b1;
        end
    end

    int cyc = 0;
    int start_cyc = 0;
    logic [15:0][31:0] launches[$];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (perm_start) begin
            start_cyc = cyc;
            launches.push_back(perm_state);
        end
    end

    typedef struct {
        int              len;
        bit              hello;
        logic [7:0]      base;
        int              pulses;
        logic [0:7][31:0] l1;
        logic [31:0]     w0x;
        int              lat;
    } vec_t;

    vec_t  tbl[6];
    string hs = "Hello, world!\n";

    function automatic logic [7:0] msg_byte(input vec_t v, input int k);
        if (v.hello) return 8'(hs[k]);
        return 8'(v.base + 8'(k));
    endfunction

    task automatic send(input vec_t v);
        int k = 0;
        int g = 0;
        while (k < v.len && g < 2000) begin
            @(negedge clk);
            g++;
            if (in_ready) begin
                in_valid = 1'b1;
                in_data  = msg_byte(v, k);
                in_last  = (k == v.len - 1);
                k++;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bytes_sent", 32'(k), 32'(v.len));
    endtask

    task automatic run_vec(input int idx);
        vec_t v = tbl[idx];
        logic [15:0][31:0] st, l, l2;
        int g = 0;
        int sv_cyc;
        launches.delete();
        lat_cfg = v.lat;
        send(v);
        while (!state_valid && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("v%0d_valid", idx), state_valid, 1'b1);
        sv_cyc = cyc;
        st = '0;
        l  = st;
        for (int i = 0; i < 8; i++) l[i] = st[i] ^ v.l1[i];
        st = pmodel(l);
        l2 = st;
        if (v.pulses == 2) begin
            l2[0] = l2[0] ^ v.w0x;
            st    = pmodel(l2);
        end
        chk($sformatf("v%0d_pulses", idx), 32'(launches.size()), 32'(v.pulses));
        if (launches.size() > 0) chk($sformatf("v%0d_launch1", idx), launches[0], l);
        if (v.pulses == 2 && launches.size() > 1) chk($sformatf("v%0d_launch2", idx), launches[1], l2);
        chk($sformatf("v%0d_state_out", idx), state_out, st);
        chk($sformatf("v%0d_latency", idx), 32'(sv_cyc - start_cyc), 32'(1 + v.lat));
`ifdef EAGLESONG_ABSORB_LEN_CNT_EN
        chk($sformatf("v%0d_msg_len", idx), msg_len, 32'(v.len));
`endif
        if (idx == 0) begin
            bit ok = 1'b1;
            in_valid = 1'b1;
            in_data  = 8'h5A;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (state_out !== st || state_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
            end
            in_valid = 1'b0;
            chk("hold_stable", ok, 1'b1);
        end
        state_ack = 1'b1;
        @(negedge clk);
        state_ack = 1'b0;
        chk($sformatf("v%0d_ack_valid", idx), state_valid, 1'b0);
        chk($sformatf("v%0d_ack_state", idx), state_out, 512'h0);
`ifdef EAGLESONG_ABSORB_LEN_CNT_EN
        chk($sformatf("v%0d_ack_len", idx), msg_len, 32'h0);
`endif
        @(negedge clk);
        chk($sformatf("v%0d_idle_ready", idx), in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{14, 1'b1, 8'h00, 1,
                   {32'h48656C6C, 32'h6F2C2077, 32'h6F726C64, 32'h00210A06,
                    32'h0, 32'h0, 32'h0, 32'h0}, 32'h0, 0};
        tbl[1] = '{32, 1'b0, 8'h00, 2,
                   {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                    32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F}, 32'h00000006, 2};
        tbl[2] = '{33, 1'b0, 8'h00, 2,
                   {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                    32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F}, 32'h00002006, 1};
        tbl[3] = '{1, 1'b0, 8'hAB, 1,
                   {32'h0000AB06, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 32'h0, 3};
        tbl[4] = '{4, 1'b0, 8'h11, 1,
                   {32'h11121314, 32'h00000006, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 32'h0, 0};
        tbl[5] = '{31, 1'b0, 8'h00, 1,
                   {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                    32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E06}, 32'h0, 1};

        #2 reset_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_perm_start", perm_start, 1'b0);
        chk("rst_state_valid", state_valid, 1'b0);
        chk("rst_perm_state", perm_state, 512'h0);
        chk("rst_state_out", state_out, 512'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        chk("rel_in_ready_high", in_ready, 1'b1);

        for (int i = 0; i < 4; i++) run_vec(i);

        // ack outside DONE has no effect
        state_ack = 1'b1;
        repeat (2) @(negedge clk);
        state_ack = 1'b0;
        chk("idle_ack_ready", in_ready, 1'b1);
        chk("idle_ack_valid", state_valid, 1'b0);

        for (int i = 4; i < 6; i++) run_vec(i);

        // abort during the first WAIT cycle while perm_start is high
        begin
            int g = 0;
            launches.delete();
            lat_cfg = 3;
            fork
                send(tbl[0]);
            join_none
            while (perm_start !== 1'b1 && g < 200) begin
                @(negedge clk);
                g++;
            end
            chk("abort_reached_wait", perm_start, 1'b1);
            reset_n = 1'b0;
            #1;
            chk("abort_perm_start", perm_start, 1'b0);
            chk("abort_in_ready", in_ready, 1'b0);
            chk("abort_state_valid", state_valid, 1'b0);
            chk("abort_perm_state", perm_state, 512'h0);
            chk("abort_state_out", state_out, 512'h0);
            wait fork;
            @(negedge clk);
            reset_n = 1'b1;
            @(negedge clk);
            run_vec(3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
